// File: rtl/wb_sdr_burst_master.sv
// Wishbone B3 burst initiator: seed+index pattern writes and checked reads.
// Define WBM_ACK_TIMEOUT_EN to abort a burst whose ack stalls TIMEOUT_CYC cycles.
module wb_sdr_burst_master #(
    parameter int AW          = 26,
    parameter int DW          = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [AW-1:0]   cmd_addr,
    input  logic [7:0]      cmd_len,
    input  logic [DW-1:0]   cmd_seed,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    output logic            wb_we_o,
    output logic [AW-1:0]   wb_addr_o,
    output logic [DW-1:0]   wb_dat_o,
    output logic [DW/8-1:0] wb_sel_o,
    output logic [2:0]      wb_cti_o,
    input  logic            wb_ack_i,
    input  logic [DW-1:0]   wb_dat_i,
    output logic            busy,
    output logic            done,
    input  logic            err_clr,
    output logic [15:0]     err_cnt,
    output logic            first_err_valid,
    output logic [AW-1:0]   first_err_addr,
    output logic            timeout
);

    localparam int BPB = DW / 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_dat;
    logic [7:0]    r_cnt;
    logic [7:0]    r_last;
    logic [15:0]   r_err_cnt;
    logic          r_fev;
    logic [AW-1:0] r_fea;

    logic          w_stb;
    logic          w_accept;
    logic          w_beat;
    logic          w_last;
    logic          w_mismatch;
    logic          w_abort;
    logic [2:0]    w_cti;

    assign w_stb      = (r_state == S_WR) || (r_state == S_RD);
    assign w_accept   = cmd_valid && (r_state == S_IDLE);
    assign w_beat     = w_stb && wb_ack_i;
    assign w_last     = (r_cnt == r_last);
    assign w_mismatch = (r_state == S_RD) && wb_ack_i && (wb_dat_i != r_dat);

`ifdef WBM_ACK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] r_to_cnt;
    logic          r_to_flag;

    // Fires on the last of TIMEOUT_CYC consecutive stalled strobe cycles.
    assign w_abort = w_stb && !wb_ack_i &&
                     (r_to_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_to_cnt  <= '0;
            r_to_flag <= 1'b0;
        end else begin
            r_to_flag <= w_abort;
            if (!w_stb || wb_ack_i || w_abort) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

    assign timeout = r_to_flag;
`else
    logic w_unused_to;

    assign w_abort     = 1'b0;
    assign timeout     = 1'b0;
    assign w_unused_to = TIMEOUT_CYC[0];
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_state_nxt = cmd_we ? S_WR : S_RD;
                end
            end
            S_WR, S_RD: begin
                if (w_abort || (w_beat && w_last)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_cti = 3'b000;
        if (w_stb && (r_last != 8'd0)) begin
            w_cti = w_last ? 3'b111 : 3'b010;
        end
    end

    // cmd_len of 0 wraps to a last index of 255, i.e. 256 beats.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_addr <= '0;
            r_dat  <= '0;
            r_cnt  <= '0;
            r_last <= '0;
        end else if (w_accept) begin
            r_addr <= cmd_addr;
            r_dat  <= cmd_seed;
            r_cnt  <= '0;
            r_last <= cmd_len - 8'd1;
        end else if (w_beat) begin
            r_addr <= r_addr + AW'(BPB);
            r_dat  <= r_dat + 1'b1;
            r_cnt  <= r_cnt + 8'd1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || err_clr) begin
            r_err_cnt <= '0;
            r_fev     <= 1'b0;
            r_fea     <= '0;
        end else begin
            if ((w_mismatch || w_abort) && (r_err_cnt != 16'hFFFF)) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
            if (w_mismatch && !r_fev) begin
                r_fev <= 1'b1;
                r_fea <= r_addr;
            end
        end
    end

    assign cmd_ready       = (r_state == S_IDLE);
    assign busy            = (r_state != S_IDLE);
    assign done            = (r_state == S_DONE);
    assign wb_cyc_o        = w_stb;
    assign wb_stb_o        = w_stb;
    assign wb_we_o         = (r_state == S_WR);
    assign wb_addr_o       = r_addr;
    assign wb_dat_o        = r_dat;
    assign wb_sel_o        = {BPB{w_stb}};
    assign wb_cti_o        = w_cti;
    assign err_cnt         = r_err_cnt;
    assign first_err_valid = r_fev;
    assign first_err_addr  = r_fea;

endmodule

// File: doc/wb_sdr_burst_master.md
Name: wb_sdr_burst_master

Overview:
- Wishbone B3 initiator that drives the SDRAM controller's Wishbone slave port (stb/cyc/we/addr/dat/sel/cti ↔ ack/dat).
- Executes write or read bursts from a simple command port; write data comes from a seed-plus-index pattern.
- Read data is checked against the same pattern; the block keeps error statistics.
- Sits in the bench/BIST path in front of the SDRAM controller and replaces hand-written Wishbone tasks.

Parameters:
- AW, 26, Wishbone byte-address width.
- DW, 32, Wishbone data width; bytes per beat = DW/8.
- TIMEOUT_CYC, 1024, maximum cycles stb may wait for ack (used only with the optional feature).

Ports:
- wb_clk_i  in  1  clock; all logic on the rising edge.
- wb_rst_i  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_we  in  1  1 = write burst, 0 = read/check burst.
- cmd_addr  in  AW  start byte address; must be DW/8-aligned.
- cmd_len  in  8  beat count; 0 means 256.
- cmd_seed  in  DW  pattern seed.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_stb_o  out  1  Wishbone strobe.
- wb_we_o  out  1  Wishbone write enable.
- wb_addr_o  out  AW  Wishbone byte address.
- wb_dat_o  out  DW  Wishbone write data.
- wb_sel_o  out  DW/8  byte selects; always all ones when stb=1.
- wb_cti_o  out  3  cycle type identifier.
- wb_ack_i  in  1  Wishbone acknowledge.
- wb_dat_i  in  DW  Wishbone read data.
- busy  out  1  high in WR, RD and DONE states.
- done  out  1  one-cycle pulse at burst completion.
- err_clr  in  1  clears err_cnt and first_err_valid.
- err_cnt  out  16  saturating read-mismatch count.
- first_err_valid  out  1  first_err_addr holds a captured address.
- first_err_addr  out  AW  address of the first mismatch.
- timeout  out  1  one-cycle pulse on burst abort; constant 0 without the optional feature.

Behaviour:
- Reset values: every output is 0 except cmd_ready=1; state IDLE; beat counter 0.
- Reset mid-burst: cyc/stb drop at the same edge, no done pulse, error statistics cleared.
- States:
  - IDLE: cmd_ready=1. On accept, latch addr, len, seed and we; go to WR if we=1, else RD.
  - WR/RD: cyc=stb=1 from the cycle after accept (1-cycle command-to-stb latency). we_o=1 in WR, 0 in RD.
  - DONE: cyc=stb=0, done=1 for exactly one cycle, then IDLE.
- Beat k (k = 0..N-1, N = len):
  - wb_addr_o = start + k*(DW/8), modulo 2^AW (wraps silently).
  - wb_dat_o = seed + k, modulo 2^DW.
- Beat advance: on each edge with stb && ack the beat counter increments and addr/dat/cti update on that edge, so the next beat is presented the following cycle. stb stays continuously high between beats; no gaps inserted by the master.
- Last beat: the edge with stb && ack && k == N-1 moves the FSM to DONE; cyc/stb are low in the next cycle.
- cti_o: N == 1 → 3'b000. N > 1 → 3'b010 for beats 0..N-2, 3'b111 on beat N-1.
- Read check: on ack in RD, compare wb_dat_i with seed+k.
  - On mismatch, err_cnt increments and saturates at 16'hFFFF.
  - If first_err_valid=0, capture wb_addr_o into first_err_addr and set first_err_valid=1.
- err_clr: takes effect at the next edge. If it coincides with a mismatch, clear wins and that mismatch is not counted.
- ack while cyc=0 is ignored. Read data is not sampled without ack.
- cmd_valid outside IDLE is not accepted (cmd_ready=0); the requester holds it.

Optional Feature:
- Macro: WBM_ACK_TIMEOUT_EN.
- Enabled:
  - A counter counts consecutive cycles with stb=1 and ack=0; it resets on every ack.
  - When it reaches TIMEOUT_CYC the burst aborts: cyc/stb drop at the next edge, timeout=1 and done=1 in the same single DONE cycle, err_cnt +1 (saturating).
- Disabled: no counter; timeout is tied to 0; the master waits for ack indefinitely.

Test Plan:
- Reset then write addr=0x000100, len=4, seed=0xA5A50000:
  - Required: four acks at addresses 0x100, 0x104, 0x108, 0x10C with data 0xA5A50000..0xA5A50003.
  - Required: cti 010,010,010,111; one done pulse.
- Read back the same region with the same seed → err_cnt=0, first_err_valid=0.
- Read back with seed=0xA5A50001 → err_cnt=4, first_err_addr=0x000100.
- Slave ack stalls of 0–5 random cycles, len=0 (256 beats) from addr 0x3FFFFF0 → 256 beats, address wraps to 0x0000000 after 0x3FFFFFC, data correct, stb never drops mid-burst.
- len=1 write → cti=000, cyc high exactly one cycle with immediate ack.
- Assert wb_rst_i on beat 2 of 8 → cyc/stb low the next cycle, no done pulse, cmd_ready=1.
- With WBM_ACK_TIMEOUT_EN and TIMEOUT_CYC=16, slave never acks → abort after 16 stalled cycles, timeout=done=1 for one cycle, err_cnt=1.
